// File: rtl/cpu_bus_pkg.sv
// Shared CPU-side SRAM bus definitions: requester IDs, transfer sizes, default widths.
package cpu_bus_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order requester-ID FIFO: one entry per accepted-but-unanswered transaction.
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: storage is left unreset; an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like slave port between the IF and data requesters, routing responses in order.
// Optional `ARB_RR_EN: round-robin between simultaneous requests instead of fixed data priority.
module sram_req_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [3:0]        wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    logic lock;
    logic lock_id;
    logic sel_id;
    logic sel_req;
    logic push;
    logic pop;
    logic head_id;
    logic fifo_full;
    logic fifo_empty;

`ifdef ARB_RR_EN
    logic rr_last;  // 1 = data was granted last
`endif

    // NOTE: always_comb assigns a default first so no path leaves sel_id unassigned (no latch).
    always_comb begin
        sel_id = ID_INST;
        if (lock) begin
            sel_id = lock_id;
`ifdef ARB_RR_EN
        end else if (data_req && inst_req) begin
            sel_id = rr_last ? ID_INST : ID_DATA;
`endif
        end else if (data_req) begin
            sel_id = ID_DATA;
        end
    end

    assign sel_req = (sel_id == ID_DATA) ? data_req : inst_req;
    assign req     = sel_req & ~fifo_full;
    assign wr      = (sel_id == ID_DATA) ? data_wr    : inst_wr;
    assign size    = (sel_id == ID_DATA) ? data_size  : inst_size;
    assign wstrb   = (sel_id == ID_DATA) ? data_wstrb : inst_wstrb;
    assign addr    = (sel_id == ID_DATA) ? data_addr  : inst_addr;
    assign wdata   = (sel_id == ID_DATA) ? data_wdata : inst_wdata;

    assign push = req & addr_ok;
    assign pop  = data_ok & ~fifo_empty;

    assign inst_addr_ok = push & (sel_id == ID_INST);
    assign data_addr_ok = push & (sel_id == ID_DATA);
    assign inst_data_ok = pop & (head_id == ID_INST);
    assign data_data_ok = pop & (head_id == ID_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // A presented but unaccepted request keeps the grant until the slave takes it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock    <= 1'b0;
            lock_id <= ID_INST;
        end else if (req) begin
            lock    <= ~addr_ok;
            lock_id <= sel_id;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!resetn)   rr_last <= 1'b0;
        else if (push) rr_last <= sel_id;
    end
`endif

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (sel_id),
        .head   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule
